// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, the arbiter and the register file write port.
// The master side is the producer/register-file environment; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       pending_mask;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, wb_en, wb_rd, wb_data, pending_mask, wb_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, wb_en, wb_rd, wb_data, pending_mask, wb_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and load write-back.
// One holding buffer per source, round-robin grant with an age override on equal rd.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam logic [0:0] GNT_ALU = 1'b0;
    localparam logic [0:0] GNT_MEM = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    logic       alu_full_q, alu_full_d;
    logic       mem_full_q, mem_full_d;
    wb_req_t    alu_buf_q, alu_buf_d;
    wb_req_t    mem_buf_q, mem_buf_d;
    logic       alu_older_q, alu_older_d;
    logic [0:0] last_grant_q, last_grant_d;
    logic       wb_en_q, wb_en_d;
    wb_req_t    wb_q, wb_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;

    logic        grant_alu, grant_mem;
    logic        alu_fill, mem_fill;
    logic [31:0] pending_mask;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_full_q && mem_full_q) begin
            // Equal destinations must commit in arrival order to keep the final value right.
            if (alu_buf_q.rd == mem_buf_q.rd)
                grant_alu = alu_older_q;
            else
                grant_alu = (last_grant_q == GNT_MEM);
            grant_mem = !grant_alu;
        end else begin
            grant_alu = alu_full_q;
            grant_mem = mem_full_q;
        end
    end

    assign bus.alu_ready = !alu_full_q || grant_alu;
    assign bus.mem_ready = !mem_full_q || grant_mem;

    // Writes to x0 complete the handshake but never occupy a buffer.
    assign alu_fill = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign mem_fill = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);

    always_comb begin
        alu_full_d = alu_full_q && !grant_alu;
        alu_buf_d  = alu_buf_q;
        if (alu_fill) begin
            alu_full_d = 1'b1;
            alu_buf_d  = '{rd: bus.alu_rd, data: bus.alu_data};
        end

        mem_full_d = mem_full_q && !grant_mem;
        mem_buf_d  = mem_buf_q;
        if (mem_fill) begin
            mem_full_d = 1'b1;
            mem_buf_d  = '{rd: bus.mem_rd, data: bus.mem_data};
        end

        // A fresh fill is always younger; on a simultaneous fill the load counts as older.
        alu_older_d = alu_older_q;
        if (alu_fill)
            alu_older_d = 1'b0;
        else if (mem_fill)
            alu_older_d = 1'b1;

        wb_en_d      = grant_alu || grant_mem;
        wb_d         = wb_q;
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            wb_d         = alu_buf_q;
            last_grant_d = GNT_ALU;
        end else if (grant_mem) begin
            wb_d         = mem_buf_q;
            last_grant_d = GNT_MEM;
        end

        wb_count_d = wb_count_q + CNT_W'(wb_en_q);
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 1; r < 32; r++) begin
            pending_mask[r] = (alu_full_q && (alu_buf_q.rd == ADDR_W'(r))) ||
                              (mem_full_q && (mem_buf_q.rd == ADDR_W'(r))) ||
                              (wb_en_q    && (wb_q.rd      == ADDR_W'(r)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_full_q   <= 1'b0;
            mem_full_q   <= 1'b0;
            alu_buf_q    <= '0;
            mem_buf_q    <= '0;
            alu_older_q  <= 1'b0;
            last_grant_q <= GNT_MEM;
            wb_en_q      <= 1'b0;
            wb_q         <= '0;
            wb_count_q   <= '0;
        end else begin
            alu_full_q   <= alu_full_d;
            mem_full_q   <= mem_full_d;
            alu_buf_q    <= alu_buf_d;
            mem_buf_q    <= mem_buf_d;
            alu_older_q  <= alu_older_d;
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            wb_q         <= wb_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign bus.wb_en        = wb_en_q;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_data      = wb_q.data;
    assign bus.pending_mask = pending_mask;
    assign bus.wb_count     = wb_count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-flight and the post-reset grant order.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(32)) bus ();

    regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] rf [32];
    always @(posedge clk) if (bus.wb_en) rf[bus.wb_rd] <= bus.wb_data;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [63:0] adat;
        logic        mv;  logic [4:0] mrd; logic [63:0] mdat;
        logic        ear; logic       emr; logic        een;
        logic [4:0]  erd; logic [63:0] edat;
        logic [31:0] emask; logic [31:0] ecnt;
    } vec_t;

    vec_t vecs [35];

    function automatic vec_t v(logic av, logic [4:0] ard, logic [63:0] adat,
                               logic mv, logic [4:0] mrd, logic [63:0] mdat,
                               logic ear, logic emr, logic een, logic [4:0] erd,
                               logic [63:0] edat, logic [31:0] emask, logic [31:0] ecnt);
        vec_t r;
        r.av = av;   r.ard = ard; r.adat = adat;
        r.mv = mv;   r.mrd = mrd; r.mdat = mdat;
        r.ear = ear; r.emr = emr; r.een = een; r.erd = erd; r.edat = edat;
        r.emask = emask; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic av, logic [4:0] ard, logic [63:0] adat,
                         logic mv, logic [4:0] mrd, logic [63:0] mdat);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = mdat;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        // Single ALU write to x5
        vecs[0]  = v(1, 5, 'h1234, 0, 0, 0,      1, 1, 0, 0, 0,        'h0,    0);
        vecs[1]  = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h20,   0);
        vecs[2]  = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 5, 'h1234,   'h20,   0);
        vecs[3]  = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    1);
        // x0 writes are swallowed
        vecs[4]  = v(1, 0, 'hFFFF, 0, 0, 0,      1, 1, 0, 0, 0,        'h0,    1);
        vecs[5]  = v(1, 0, 'hFFFF, 0, 0, 0,      1, 1, 0, 0, 0,        'h0,    1);
        vecs[6]  = v(1, 0, 'hFFFF, 0, 0, 0,      1, 1, 0, 0, 0,        'h0,    1);
        vecs[7]  = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    1);
        // Contention on different rd; last grant was ALU so MEM goes first
        vecs[8]  = v(1, 3, 'h33,   1, 7, 'h77,   1, 1, 0, 0, 0,        'h0,    1);
        vecs[9]  = v(1, 3, 'h33,   1, 7, 'h77,   0, 1, 0, 0, 0,        'h88,   1);
        vecs[10] = v(1, 3, 'h33,   1, 7, 'h77,   1, 0, 1, 7, 'h77,     'h88,   1);
        vecs[11] = v(1, 3, 'h33,   1, 7, 'h77,   0, 1, 1, 3, 'h33,     'h88,   2);
        vecs[12] = v(1, 3, 'h33,   1, 7, 'h77,   1, 0, 1, 7, 'h77,     'h88,   3);
        vecs[13] = v(0, 0, 0,      0, 0, 0,      0, 1, 1, 3, 'h33,     'h88,   4);
        vecs[14] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 7, 'h77,     'h88,   5);
        vecs[15] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 3, 'h33,     'h08,   6);
        vecs[16] = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    7);
        // MEM x9 one cycle ahead of ALU x9
        vecs[17] = v(0, 0, 0,      1, 9, 'hA,    1, 1, 0, 0, 0,        'h0,    7);
        vecs[18] = v(1, 9, 'hB,    0, 0, 0,      1, 1, 0, 0, 0,        'h200,  7);
        vecs[19] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 9, 'hA,      'h200,  7);
        vecs[20] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 9, 'hB,      'h200,  8);
        vecs[21] = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    9);
        // MEM-only write to set last grant = MEM, then backpressure on MEM
        vecs[22] = v(0, 0, 0,      1, 2, 'h22,   1, 1, 0, 0, 0,        'h0,    9);
        vecs[23] = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h4,    9);
        vecs[24] = v(1, 6, 'h66,   1, 1, 'h11,   1, 1, 1, 2, 'h22,     'h4,    9);
        vecs[25] = v(0, 0, 0,      1, 4, 'h44,   1, 0, 0, 0, 0,        'h42,   10);
        vecs[26] = v(0, 0, 0,      1, 4, 'h44,   1, 1, 1, 6, 'h66,     'h42,   10);
        vecs[27] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 1, 'h11,     'h12,   11);
        vecs[28] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 4, 'h44,     'h10,   12);
        vecs[29] = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    13);
        // Same rd filled together with last grant = MEM: age beats round-robin
        vecs[30] = v(1, 12, 'hB1,  1, 12, 'hB2,  1, 1, 0, 0, 0,        'h0,    13);
        vecs[31] = v(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0,        'h1000, 13);
        vecs[32] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 12, 'hB2,    'h1000, 13);
        vecs[33] = v(0, 0, 0,      0, 0, 0,      1, 1, 1, 12, 'hB1,    'h1000, 14);
        vecs[34] = v(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 0,        'h0,    15);

        #12;
        chk("reset wb_en",     64'(bus.wb_en), 0);
        chk("reset wb_rd",     64'(bus.wb_rd), 0);
        chk("reset wb_data",   bus.wb_data, 0);
        chk("reset mask",      64'(bus.pending_mask), 0);
        chk("reset wb_count",  64'(bus.wb_count), 0);
        chk("reset alu_ready", 64'(bus.alu_ready), 1);
        chk("reset mem_ready", 64'(bus.mem_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
            #3;
            chk($sformatf("v%0d alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].ear));
            chk($sformatf("v%0d mem_ready", i), 64'(bus.mem_ready), 64'(vecs[i].emr));
            chk($sformatf("v%0d wb_en", i),     64'(bus.wb_en),     64'(vecs[i].een));
            if (vecs[i].een) begin
                chk($sformatf("v%0d wb_rd", i),   64'(bus.wb_rd), 64'(vecs[i].erd));
                chk($sformatf("v%0d wb_data", i), bus.wb_data,    vecs[i].edat);
            end
            chk($sformatf("v%0d mask", i),     64'(bus.pending_mask), 64'(vecs[i].emask));
            chk($sformatf("v%0d wb_count", i), 64'(bus.wb_count),     64'(vecs[i].ecnt));
            @(posedge clk); #1;
        end
        chk("rf x9 final",  rf[9],  'hB);
        chk("rf x12 final", rf[12], 'hB1);

        // Fill both buffers, then reset asynchronously between edges
        drive(1, 20, 'h2020, 1, 21, 'h2121);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        chk("pre-reset mask", 64'(bus.pending_mask), 64'h30_0000);
        #2 rst = 1'b1;
        #1;
        chk("async rst wb_en",     64'(bus.wb_en), 0);
        chk("async rst wb_rd",     64'(bus.wb_rd), 0);
        chk("async rst wb_data",   bus.wb_data, 0);
        chk("async rst mask",      64'(bus.pending_mask), 0);
        chk("async rst alu_ready", 64'(bus.alu_ready), 1);
        chk("async rst mem_ready", 64'(bus.mem_ready), 1);
        chk("async rst wb_count",  64'(bus.wb_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset leaves last grant = MEM, so a simultaneous different-rd pair grants ALU first
        drive(1, 10, 'hA0, 1, 11, 'hB0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        chk("post-rst alu_ready", 64'(bus.alu_ready), 1);
        chk("post-rst mem_ready", 64'(bus.mem_ready), 0);
        @(posedge clk); #1;
        chk("post-rst 1st wb_en",   64'(bus.wb_en), 1);
        chk("post-rst 1st wb_rd",   64'(bus.wb_rd), 10);
        chk("post-rst 1st wb_data", bus.wb_data, 'hA0);
        @(posedge clk); #1;
        chk("post-rst 2nd wb_rd",   64'(bus.wb_rd), 11);
        chk("post-rst 2nd wb_data", bus.wb_data, 'hB0);
        chk("post-rst wb_count",    64'(bus.wb_count), 1);
        @(posedge clk); #1;
        chk("post-rst idle wb_en",  64'(bus.wb_en), 0);
        chk("post-rst final count", 64'(bus.wb_count), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
